// File: rtl/mpsoc_dct_trace_arbiter.sv
// Round-robin arbiter that merges two Nios II data-trace streams into one trace RAM.
// Frames are tagged with their source CPU and written one cycle after acceptance.
module mpsoc_dct_trace_arbiter #(
  parameter int ADDR_W = 9,
  parameter bit WRAP   = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              trig_stop,
  input  logic [29:0]       c0_dct_buffer,
  input  logic [3:0]        c0_dct_count,
  input  logic              c0_valid,
  output logic              c0_ready,
  input  logic [29:0]       c1_dct_buffer,
  input  logic [3:0]        c1_dct_count,
  input  logic              c1_valid,
  output logic              c1_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [34:0]       mem_wdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic [1:0]        state,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STOP = 2'b10} state_e;

  state_e              state_q;
  logic                rr_pri_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic                wrapped_q;
  logic [15:0]         stall_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [34:0]         mem_wdata_q;

  logic        run;
  logic        grant_vld;
  logic        grant_src;
  logic        contended;
  logic [3:0]  sel_cnt;
  logic [29:0] sel_buf;
  logic        do_write;
  logic        last;
  logic        stall_hit;

  // Contention resolves by rr_pri; otherwise the lone valid source wins.
  always_comb begin
    run       = (state_q == RUN);
    contended = c0_valid & c1_valid;
    grant_vld = run & (c0_valid | c1_valid);
    grant_src = contended ? rr_pri_q : c1_valid;
    c0_ready  = grant_vld & ~grant_src;
    c1_ready  = grant_vld & grant_src;
    sel_cnt   = grant_src ? c1_dct_count  : c0_dct_count;
    sel_buf   = grant_src ? c1_dct_buffer : c0_dct_buffer;
    do_write  = grant_vld & (sel_cnt != 4'd0);
    last      = (wr_ptr_q == {ADDR_W{1'b1}});
    stall_hit = run & ((c0_valid & ~c0_ready) | (c1_valid & ~c1_ready));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_pri_q    <= 1'b0;
      wr_ptr_q    <= '0;
      wrapped_q   <= 1'b0;
      stall_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q   <= RUN;
            wr_ptr_q  <= '0;
            wrapped_q <= 1'b0;
            stall_q   <= '0;
          end
        end
        RUN: begin
          if (do_write) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= wr_ptr_q;
            mem_wdata_q <= {grant_src, sel_cnt, sel_buf};
            // Without WRAP the pointer parks on the last entry and capture stops.
            if (last) begin
              if (WRAP) begin
                wr_ptr_q  <= '0;
                wrapped_q <= 1'b1;
              end
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
          end
          if (grant_vld && contended) rr_pri_q <= ~grant_src;
          if (stall_hit && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
          if (!enable)
            state_q <= IDLE;
          else if (trig_stop || (!WRAP && do_write && last))
            state_q <= STOP;
        end
        STOP: begin
          if (!enable) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_ptr    = wr_ptr_q;
  assign wrapped   = wrapped_q;
  assign state     = state_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mpsoc_dct_trace_arbiter.sv
// Bench for the trace arbiter: two small-RAM instances (wrap / no-wrap) share stimulus
// and are each checked every cycle against a queue-free behavioural model.
module tb_mpsoc_dct_trace_arbiter;
  localparam int AW   = 2;
  localparam int MAXP = (1 << AW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, enable, trig_stop;
  logic [29:0] c0b, c1b;
  logic [3:0]  c0c, c1c;
  logic        c0v, c1v;

  logic          r0_o[2], r1_o[2], we_o[2], wrap_o[2];
  logic [AW-1:0] addr_o[2], ptr_o[2];
  logic [34:0]   wd_o[2];
  logic [1:0]    st_o[2];
  logic [15:0]   stall_o[2];

  mpsoc_dct_trace_arbiter #(.ADDR_W(AW), .WRAP(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .trig_stop(trig_stop),
    .c0_dct_buffer(c0b), .c0_dct_count(c0c), .c0_valid(c0v), .c0_ready(r0_o[0]),
    .c1_dct_buffer(c1b), .c1_dct_count(c1c), .c1_valid(c1v), .c1_ready(r1_o[0]),
    .mem_we(we_o[0]), .mem_addr(addr_o[0]), .mem_wdata(wd_o[0]), .wr_ptr(ptr_o[0]),
    .wrapped(wrap_o[0]), .state(st_o[0]), .stall_cnt(stall_o[0]));

  mpsoc_dct_trace_arbiter #(.ADDR_W(AW), .WRAP(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .trig_stop(trig_stop),
    .c0_dct_buffer(c0b), .c0_dct_count(c0c), .c0_valid(c0v), .c0_ready(r0_o[1]),
    .c1_dct_buffer(c1b), .c1_dct_count(c1c), .c1_valid(c1v), .c1_ready(r1_o[1]),
    .mem_we(we_o[1]), .mem_addr(addr_o[1]), .mem_wdata(wd_o[1]), .wr_ptr(ptr_o[1]),
    .wrapped(wrap_o[1]), .state(st_o[1]), .stall_cnt(stall_o[1]));

  // Model state per instance: index 0 wraps, index 1 stops when full.
  int m_st[2], m_ptr[2], m_wr[2], m_stall[2], m_pri[2], m_we[2], m_addr[2];
  logic [34:0] m_data[2];

  int nerr = 0;
  int nchk = 0;

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[dut%0d]: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic exp_ready(input int k, output bit r0, output bit r1);
    int g;
    r0 = 0; r1 = 0;
    if (m_st[k] == 1 && (c0v || c1v)) begin
      if (c0v && c1v) g = m_pri[k];
      else g = c1v ? 1 : 0;
      r0 = (g == 0);
      r1 = (g == 1);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_ptr[k] = 0; m_wr[k] = 0; m_stall[k] = 0;
      m_pri[k] = 0; m_we[k] = 0; m_addr[k] = 0; m_data[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    bit r0, r1, full;
    int g, cnt;
    exp_ready(k, r0, r1);
    m_we[k] = 0;
    full = 0;
    case (m_st[k])
      0: if (enable) begin
        m_st[k] = 1; m_ptr[k] = 0; m_wr[k] = 0; m_stall[k] = 0;
      end
      1: begin
        g = r1 ? 1 : 0;
        cnt = g ? int'(c1c) : int'(c0c);
        if ((r0 || r1) && cnt != 0) begin
          m_we[k] = 1;
          m_addr[k] = m_ptr[k];
          m_data[k] = g ? {1'b1, c1c, c1b} : {1'b0, c0c, c0b};
          if (m_ptr[k] == MAXP) begin
            if (k == 0) begin m_ptr[k] = 0; m_wr[k] = 1; end
            else full = 1;
          end else m_ptr[k] = m_ptr[k] + 1;
        end
        if (c0v && c1v) m_pri[k] = 1 - g;
        if (((c0v && !r0) || (c1v && !r1)) && m_stall[k] < 65535) m_stall[k] = m_stall[k] + 1;
        if (!enable) m_st[k] = 0;
        else if (trig_stop || full) m_st[k] = 2;
      end
      default: if (!enable) m_st[k] = 0;
    endcase
  endtask

  task automatic compare_all();
    bit r0, r1;
    for (int k = 0; k < 2; k++) begin
      exp_ready(k, r0, r1);
      check("c0_ready", k, 64'(r0_o[k]), 64'(r0));
      check("c1_ready", k, 64'(r1_o[k]), 64'(r1));
      check("state", k, 64'(st_o[k]), 64'(m_st[k]));
      check("wr_ptr", k, 64'(ptr_o[k]), 64'(m_ptr[k]));
      check("wrapped", k, 64'(wrap_o[k]), 64'(m_wr[k]));
      check("stall_cnt", k, 64'(stall_o[k]), 64'(m_stall[k]));
      check("mem_we", k, 64'(we_o[k]), 64'(m_we[k]));
      if (m_we[k] != 0) begin
        check("mem_addr", k, 64'(addr_o[k]), 64'(m_addr[k]));
        check("mem_wdata", k, 64'(wd_o[k]), 64'(m_data[k]));
      end
    end
  endtask

  // Called just after a negedge with inputs set; checks, then advances one clock.
  task automatic cycle();
    #1 compare_all();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    c0v = 0; c1v = 0; c0c = 0; c1c = 0; c0b = '0; c1b = '0; trig_stop = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    enable = 0;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    reset_n = 1; enable = 0; idle_inputs();
    @(negedge clk);

    // 1: single frame from CPU0
    do_reset();
    enable = 1; cycle();
    c0v = 1; c0c = 4'd3; c0b = 30'h1234567;
    #1 check("lit_c0_ready", 0, 64'(r0_o[0]), 64'd1);
    cycle();
    c0v = 0;
    check("lit_we", 0, 64'(we_o[0]), 64'd1);
    check("lit_addr", 0, 64'(addr_o[0]), 64'd0);
    check("lit_wdata", 0, 64'(wd_o[0]), {29'd0, 1'b0, 4'd3, 30'h1234567});
    check("lit_ptr", 0, 64'(ptr_o[0]), 64'd1);
    cycle();

    // 2: both CPUs contend for 4 cycles
    do_reset();
    enable = 1; cycle();
    c0v = 1; c0c = 4'd5; c0b = 30'h0AAAAAA;
    c1v = 1; c1c = 4'd6; c1b = 30'h0555555;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) check("lit_src1_ready", 0, 64'(r1_o[0]), 64'd1);
      cycle();
    end
    c0v = 0; c1v = 0;
    check("lit_last_src", 0, 64'(wd_o[0][34]), 64'd1);
    check("lit_last_addr", 0, 64'(addr_o[0]), 64'd3);
    cycle();
    check("lit_stall", 0, 64'(stall_o[0]), 64'd4);
    check("lit_stall", 1, 64'(stall_o[1]), 64'd4);
    check("lit_nowrap_stop", 1, 64'(st_o[1]), 64'd2);

    // 3/4: five frames from CPU0 -- wrap vs stop-when-full
    do_reset();
    enable = 1; cycle();
    c0v = 1; c0c = 4'd7;
    for (int i = 0; i < 5; i++) begin
      c0b = 30'(i + 100);
      if (i == 4) #1 check("lit_5th_ready", 1, 64'(r0_o[1]), 64'd0);
      cycle();
    end
    c0v = 0;
    check("lit_wrap_addr", 0, 64'(addr_o[0]), 64'd0);
    cycle();
    check("lit_wrap_ptr", 0, 64'(ptr_o[0]), 64'd1);
    check("lit_wrapped", 0, 64'(wrap_o[0]), 64'd1);
    check("lit_full_ptr", 1, 64'(ptr_o[1]), 64'd3);
    check("lit_full_state", 1, 64'(st_o[1]), 64'd2);
    check("lit_full_wrapped", 1, 64'(wrap_o[1]), 64'd0);

    // 5: zero-count frame discarded, then stop trigger with a live frame
    do_reset();
    enable = 1; cycle();
    c1v = 1; c1c = 4'd0; c1b = 30'h3FFFFFF;
    cycle();
    c1v = 0;
    check("lit_zero_nowrite", 0, 64'(we_o[0]), 64'd0);
    c0v = 1; c0c = 4'd2; c0b = 30'h0BEEF00; trig_stop = 1;
    cycle();
    c0v = 0; trig_stop = 0;
    check("lit_trig_we", 0, 64'(we_o[0]), 64'd1);
    check("lit_trig_state", 0, 64'(st_o[0]), 64'd2);
    cycle();
    enable = 0; cycle();
    check("lit_idle", 0, 64'(st_o[0]), 64'd0);
    // enable dropped while a frame is accepted: still written, then IDLE
    enable = 1; cycle();
    c0v = 1; c0c = 4'd1; c0b = 30'h0000011; enable = 0;
    cycle();
    c0v = 0;
    cycle();

    // mixed traffic with occasional zero counts and a late stop
    do_reset();
    enable = 1; cycle();
    for (int i = 0; i < 24; i++) begin
      c0v = (i % 3 != 0); c1v = (i % 2 == 0);
      c0c = 4'(i % 4); c1c = 4'((i + 1) % 5);
      c0b = 30'(i * 37); c1b = 30'(i * 91 + 5);
      trig_stop = (i == 20);
      cycle();
    end
    idle_inputs();
    cycle();

    // 6: reset asserted while a write is pending
    do_reset();
    enable = 1; cycle();
    c0v = 1; c0c = 4'd4; c0b = 30'h0123456;
    cycle();
    c0v = 0;
    check("lit_pending_we", 0, 64'(we_o[0]), 64'd1);
    do_reset();
    check("lit_rst_we", 0, 64'(we_o[0]), 64'd0);
    check("lit_rst_state", 0, 64'(st_o[0]), 64'd0);
    check("lit_rst_addr", 0, 64'(addr_o[0]), 64'd0);
    cycle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
